// File: rtl/horner_sched_if.sv
// Handshake and datapath-control bundle between the Horner scheduler and its surroundings.
// master: the scheduler side. slave: the front-end/datapath side.
interface horner_sched_if #(
  parameter int LANES    = 16,
  parameter int NUM_PASS = 2,
  parameter int ORDER    = 10
);
  localparam int CW  = $clog2(ORDER + 1);
  localparam int CHW = $clog2(LANES * NUM_PASS);

  logic           srdyi;
  logic           drdyi;
  logic           iss_valid;
  logic [CW-1:0]  coeff_sel;
  logic [CHW-1:0] ch_sel;
  logic           acc_init;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic           srdyo;
  logic           busy;
  logic           overrun;

  modport master (
    input  srdyi, drdyi,
    output iss_valid, coeff_sel, ch_sel, acc_init, wr_en, wr_ch, srdyo, busy, overrun
  );
  modport slave (
    output srdyi, drdyi,
    input  iss_valid, coeff_sel, ch_sel, acc_init, wr_en, wr_ch, srdyo, busy, overrun
  );
endinterface

// File: rtl/horner_sched.sv
// Issue scheduler for the shared Horner MAC: LANES-interleaved passes over all channels,
// pipelined write-back strobes and a backpressured frame-done handshake.
module horner_sched #(
  parameter int LANES    = 16,
  parameter int NUM_PASS = 2,
  parameter int ORDER    = 10,
  parameter int PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            GlobalReset,
  horner_sched_if.master  bus
);
  localparam int NUM_CH = LANES * NUM_PASS;
  localparam int CW     = $clog2(ORDER + 1);
  localparam int CHW    = $clog2(NUM_CH);
  localparam int LW     = (LANES > 1)    ? $clog2(LANES)    : 1;
  localparam int PW     = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lane;
  logic [CW-1:0]   r_step;
  logic [PW-1:0]   r_pass;
  logic [DW-1:0]   r_drain;
  logic            r_pending, r_overrun;
  logic            r_iss, r_acc, r_srdyo, r_busy;
  logic [CW-1:0]   r_coeff;
  logic [CHW-1:0]  r_ch;
  logic [PIPE_LAT-1:0]           r_vld_pipe;
  logic [PIPE_LAT-1:0][CHW-1:0]  r_ch_pipe;

  logic            w_last_lane, w_last_step, w_last_pass, w_end;
  logic [LW-1:0]   w_lane_nx;
  logic [CW-1:0]   w_step_nx;
  logic [PW-1:0]   w_pass_nx;
  logic [CHW-1:0]  w_ch_nx;
  logic            w_start, w_srdy_busy;

  always_comb begin
    w_last_lane = (r_lane == LW'(LANES - 1));
    w_last_step = (r_step == '0);
    w_last_pass = (r_pass == PW'(NUM_PASS - 1));
    w_end       = w_last_lane && w_last_step && w_last_pass;
    w_lane_nx   = w_last_lane ? '0 : r_lane + 1'b1;
    w_step_nx   = !w_last_lane ? r_step : (w_last_step ? CW'(ORDER) : r_step - 1'b1);
    w_pass_nx   = (w_last_lane && w_last_step) ? r_pass + 1'b1 : r_pass;
    w_ch_nx     = CHW'(w_pass_nx) * CHW'(LANES) + CHW'(w_lane_nx);
    // A start in DONE only happens once the current frame has been accepted.
    w_start     = (r_state == IDLE && bus.srdyi) ||
                  (r_state == DONE && bus.drdyi && (r_pending || bus.srdyi));
    w_srdy_busy = bus.srdyi && (r_state != IDLE) &&
                  !(r_state == DONE && bus.drdyi && !r_pending);
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state    <= IDLE;
      r_lane     <= '0;
      r_step     <= '0;
      r_pass     <= '0;
      r_drain    <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_iss      <= 1'b0;
      r_acc      <= 1'b0;
      r_srdyo    <= 1'b0;
      r_busy     <= 1'b0;
      r_coeff    <= '0;
      r_ch       <= '0;
      r_vld_pipe <= '0;
      r_ch_pipe  <= '0;
    end else begin
      // Write-back tracks the final (step 0) issue through the datapath latency.
      r_vld_pipe[0] <= r_iss && (r_coeff == '0);
      r_ch_pipe[0]  <= r_ch;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_ch_pipe[i]  <= r_ch_pipe[i-1];
      end

      if (w_srdy_busy) begin
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end

      if (w_start) begin
        r_state   <= ISSUE;
        r_lane    <= '0;
        r_step    <= CW'(ORDER);
        r_pass    <= '0;
        r_iss     <= 1'b1;
        r_coeff   <= CW'(ORDER);
        r_ch      <= '0;
        r_acc     <= 1'b1;
        r_busy    <= 1'b1;
        r_srdyo   <= 1'b0;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;
          ISSUE: begin
            if (w_end) begin
              r_state <= DRAIN;
              r_lane  <= '0;
              r_step  <= '0;
              r_pass  <= '0;
              r_iss   <= 1'b0;
              r_coeff <= '0;
              r_ch    <= '0;
              r_acc   <= 1'b0;
            end else begin
              r_lane  <= w_lane_nx;
              r_step  <= w_step_nx;
              r_pass  <= w_pass_nx;
              r_coeff <= w_step_nx;
              r_ch    <= w_ch_nx;
              r_acc   <= (w_step_nx == CW'(ORDER));
            end
          end
          DRAIN: begin
            if (r_drain == DW'(PIPE_LAT - 1)) begin
              r_drain <= '0;
              r_state <= DONE;
              r_srdyo <= 1'b1;
            end else begin
              r_drain <= r_drain + 1'b1;
            end
          end
          DONE: begin
            if (bus.drdyi) begin
              r_srdyo <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.iss_valid = r_iss;
  assign bus.coeff_sel = r_coeff;
  assign bus.ch_sel    = r_ch;
  assign bus.acc_init  = r_acc;
  assign bus.wr_en     = r_vld_pipe[PIPE_LAT-1];
  assign bus.wr_ch     = r_ch_pipe[PIPE_LAT-1];
  assign bus.srdyo     = r_srdyo;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_horner_sched.sv
// Scoreboard bench for horner_sched: default instance plus a small-parameter instance.
module tb_horner_sched;
  logic clk = 1'b0;
  logic GlobalReset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  horner_sched_if #(.LANES(16), .NUM_PASS(2), .ORDER(10)) bus0 ();
  horner_sched_if #(.LANES(4),  .NUM_PASS(3), .ORDER(2))  bus1 ();

  horner_sched #(.LANES(16), .NUM_PASS(2), .ORDER(10), .PIPE_LAT(4)) u_dut (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus0));
  horner_sched #(.LANES(4), .NUM_PASS(3), .ORDER(2), .PIPE_LAT(4)) u_swp (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus1));

  typedef struct { int cyc; int coeff; int ch; int acc; } iss_t;
  typedef struct { int cyc; int ch; } wr_t;
  iss_t q_iss0[$], q_iss1[$];
  wr_t  q_wr0[$],  q_wr1[$];

  // Expected issue stream and write-backs for a frame whose srdyi is seen in cycle b.
  task automatic push_frame(input int which, input int b, input int L, input int P,
                            input int O, input int PL);
    int n, blk, idx, p, w, stp, ln;
    iss_t e;
    wr_t  r;
    blk = (O + 1) * L;
    n = P * blk;
    for (int k = 1; k <= n; k++) begin
      idx = k - 1; p = idx / blk; w = idx % blk;
      stp = O - w / L; ln = w % L;
      e = '{b + k, stp, p * L + ln, (stp == O) ? 1 : 0};
      if (which == 0) q_iss0.push_back(e); else q_iss1.push_back(e);
    end
    for (int c = 0; c < L * P; c++) begin
      r = '{b + 1 + (c / L) * blk + O * L + (c % L) + PL, c};
      if (which == 0) q_wr0.push_back(r); else q_wr1.push_back(r);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus0.srdyi = 1'b0; bus0.drdyi = 1'b1;
    bus1.srdyi = 1'b0; bus1.drdyi = 1'b1;
    GlobalReset = 1'b0;
    repeat (3) next();
    total++;
    if ({bus0.iss_valid, bus0.coeff_sel, bus0.ch_sel, bus0.acc_init, bus0.wr_en, bus0.wr_ch,
         bus0.srdyo, bus0.busy, bus0.overrun} !== '0) begin
      bad++; $display("FAIL reset_outs0 got iss=%b coeff=%0d ch=%0d busy=%b srdyo=%b want all 0",
                      bus0.iss_valid, bus0.coeff_sel, bus0.ch_sel, bus0.busy, bus0.srdyo);
    end
    GlobalReset = 1'b1;
    repeat (2) next();
    total++;
    if ({bus0.iss_valid, bus0.wr_en, bus0.srdyo, bus0.busy, bus0.overrun} !== 5'b0) begin
      bad++; $display("FAIL idle_outs0 got %b want 00000",
                      {bus0.iss_valid, bus0.wr_en, bus0.srdyo, bus0.busy, bus0.overrun});
    end
    total++;
    if ({bus1.iss_valid, bus1.coeff_sel, bus1.ch_sel, bus1.acc_init, bus1.wr_en, bus1.wr_ch,
         bus1.srdyo, bus1.busy, bus1.overrun} !== '0) begin
      bad++; $display("FAIL reset_outs1 got iss=%b busy=%b want 0", bus1.iss_valid, bus1.busy);
    end
  endtask

  task automatic test_single();
    int base, rel, n_iss;
    bus0.drdyi = 1'b1;
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    n_iss = 0;
    while (cyc - base <= 362) begin
      rel = cyc - base;
      total++;
      if (bus0.srdyo !== (rel == 357)) begin
        bad++; if (bad < 30) $display("FAIL single_srdyo rel=%0d got %b want %b", rel, bus0.srdyo, rel == 357);
      end
      total++;
      if (bus0.busy !== (rel <= 357)) begin
        bad++; if (bad < 30) $display("FAIL single_busy rel=%0d got %b want %b", rel, bus0.busy, rel <= 357);
      end
      if (!bus0.iss_valid) begin
        total++;
        if ({bus0.coeff_sel, bus0.ch_sel, bus0.acc_init} !== '0) begin
          bad++; if (bad < 30) $display("FAIL single_idle_sel rel=%0d got coeff=%0d ch=%0d acc=%b want 0",
                                        rel, bus0.coeff_sel, bus0.ch_sel, bus0.acc_init);
        end
      end
      n_iss += int'(bus0.iss_valid);
      next();
    end
    total++;
    if (n_iss !== 352) begin bad++; $display("FAIL single_iss_count got %0d want 352", n_iss); end
    total++;
    if (q_iss0.size() + q_wr0.size() !== 0) begin
      bad++; $display("FAIL single_sb_left got %0d want 0", q_iss0.size() + q_wr0.size());
    end
  endtask

  task automatic test_backpressure();
    int base, rel;
    bus0.drdyi = 1'b0;
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    while (cyc - base <= 405) begin
      rel = cyc - base;
      bus0.drdyi = (rel >= 400);
      total++;
      if (bus0.srdyo !== (rel >= 357 && rel <= 400)) begin
        bad++; if (bad < 30) $display("FAIL bp_srdyo rel=%0d got %b want %b", rel, bus0.srdyo, rel >= 357 && rel <= 400);
      end
      total++;
      if (bus0.busy !== (rel <= 400)) begin
        bad++; if (bad < 30) $display("FAIL bp_busy rel=%0d got %b want %b", rel, bus0.busy, rel <= 400);
      end
      next();
    end
    bus0.drdyi = 1'b1;
    total++;
    if (q_iss0.size() + q_wr0.size() !== 0) begin
      bad++; $display("FAIL bp_sb_left got %0d want 0", q_iss0.size() + q_wr0.size());
    end
  endtask

  task automatic test_pending();
    int base, rel;
    logic want_iss;
    bus0.drdyi = 1'b1;
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    while (cyc - base <= 720) begin
      rel = cyc - base;
      bus0.srdyi = (rel == 100);
      if (rel == 100) push_frame(0, base + 357, 16, 2, 10, 4);
      want_iss = (rel >= 1 && rel <= 352) || (rel >= 358 && rel <= 709);
      total++;
      if (bus0.iss_valid !== want_iss) begin
        bad++; if (bad < 30) $display("FAIL pend_iss rel=%0d got %b want %b", rel, bus0.iss_valid, want_iss);
      end
      total++;
      if (bus0.srdyo !== (rel == 357 || rel == 714)) begin
        bad++; if (bad < 30) $display("FAIL pend_srdyo rel=%0d got %b want %b", rel, bus0.srdyo, rel == 357 || rel == 714);
      end
      total++;
      if (bus0.overrun !== 1'b0) begin
        bad++; if (bad < 30) $display("FAIL pend_overrun rel=%0d got %b want 0", rel, bus0.overrun);
      end
      next();
    end
    bus0.srdyi = 1'b0;
    total++;
    if (q_iss0.size() + q_wr0.size() !== 0) begin
      bad++; $display("FAIL pend_sb_left got %0d want 0", q_iss0.size() + q_wr0.size());
    end
  endtask

  task automatic test_overrun();
    int base, rel, n_done;
    bus0.drdyi = 1'b1;
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    push_frame(0, base + 357, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    n_done = 0;
    while (cyc - base <= 760) begin
      rel = cyc - base;
      bus0.srdyi = (rel == 50 || rel == 60);
      total++;
      if (bus0.overrun !== (rel >= 61)) begin
        bad++; if (bad < 30) $display("FAIL ovr_flag rel=%0d got %b want %b", rel, bus0.overrun, rel >= 61);
      end
      n_done += int'(bus0.srdyo);
      next();
    end
    bus0.srdyi = 1'b0;
    total++;
    if (n_done !== 2) begin bad++; $display("FAIL ovr_frames got %0d want 2", n_done); end
    total++;
    if (q_iss0.size() + q_wr0.size() !== 0) begin
      bad++; $display("FAIL ovr_sb_left got %0d want 0", q_iss0.size() + q_wr0.size());
    end
  endtask

  task automatic test_midreset();
    int base, rel;
    bus0.drdyi = 1'b1;
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    while (cyc - base < 200) next();
    GlobalReset = 1'b0;
    #1;
    total++;
    if ({bus0.iss_valid, bus0.coeff_sel, bus0.ch_sel, bus0.acc_init, bus0.wr_en, bus0.wr_ch,
         bus0.srdyo, bus0.busy, bus0.overrun} !== '0) begin
      bad++; $display("FAIL midrst_outs got iss=%b busy=%b ovr=%b want all 0",
                      bus0.iss_valid, bus0.busy, bus0.overrun);
    end
    q_iss0.delete();
    q_wr0.delete();
    next(); next();
    GlobalReset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      total++;
      if ({bus0.iss_valid, bus0.srdyo, bus0.busy} !== 3'b0) begin
        bad++; if (bad < 30) $display("FAIL midrst_quiet i=%0d got %b want 000", i,
                                      {bus0.iss_valid, bus0.srdyo, bus0.busy});
      end
      next();
    end
    base = cyc;
    bus0.srdyi = 1'b1;
    push_frame(0, base, 16, 2, 10, 4);
    next();
    bus0.srdyi = 1'b0;
    while (cyc - base <= 360) begin
      rel = cyc - base;
      total++;
      if (bus0.srdyo !== (rel == 357)) begin
        bad++; if (bad < 30) $display("FAIL midrst_frame_srdyo rel=%0d got %b want %b", rel, bus0.srdyo, rel == 357);
      end
      next();
    end
    total++;
    if (q_iss0.size() + q_wr0.size() !== 0) begin
      bad++; $display("FAIL midrst_sb_left got %0d want 0", q_iss0.size() + q_wr0.size());
    end
  endtask

  task automatic test_sweep();
    int base, rel, n_iss, n_wr;
    bus1.drdyi = 1'b1;
    base = cyc;
    bus1.srdyi = 1'b1;
    push_frame(1, base, 4, 3, 2, 4);
    next();
    bus1.srdyi = 1'b0;
    n_iss = 0; n_wr = 0;
    while (cyc - base <= 46) begin
      rel = cyc - base;
      total++;
      if (bus1.srdyo !== (rel == 41)) begin
        bad++; if (bad < 30) $display("FAIL sweep_srdyo rel=%0d got %b want %b", rel, bus1.srdyo, rel == 41);
      end
      n_iss += int'(bus1.iss_valid);
      n_wr  += int'(bus1.wr_en);
      next();
    end
    total++;
    if (n_iss !== 36) begin bad++; $display("FAIL sweep_iss_count got %0d want 36", n_iss); end
    total++;
    if (n_wr !== 12) begin bad++; $display("FAIL sweep_wr_count got %0d want 12", n_wr); end
    total++;
    if (q_iss1.size() + q_wr1.size() !== 0) begin
      bad++; $display("FAIL sweep_sb_left got %0d want 0", q_iss1.size() + q_wr1.size());
    end
  endtask

  initial begin
    fork
      forever begin : mon0
        iss_t e;
        wr_t  r;
        @(negedge clk);
        if (GlobalReset) begin
          while (q_iss0.size() > 0 && q_iss0[0].cyc < cyc) begin
            total++; bad++;
            if (bad < 30) $display("FAIL iss0_missing want_cyc=%0d now=%0d", q_iss0[0].cyc, cyc);
            q_iss0.delete(0);
          end
          while (q_wr0.size() > 0 && q_wr0[0].cyc < cyc) begin
            total++; bad++;
            if (bad < 30) $display("FAIL wr0_missing want_cyc=%0d ch=%0d now=%0d", q_wr0[0].cyc, q_wr0[0].ch, cyc);
            q_wr0.delete(0);
          end
          if (bus0.iss_valid) begin
            total++;
            if (q_iss0.size() == 0 || q_iss0[0].cyc != cyc) begin
              bad++; if (bad < 30) $display("FAIL iss0_unexpected cyc=%0d ch=%0d", cyc, bus0.ch_sel);
            end else begin
              e = q_iss0.pop_front();
              if (int'(bus0.coeff_sel) !== e.coeff || int'(bus0.ch_sel) !== e.ch ||
                  int'(bus0.acc_init) !== e.acc) begin
                bad++; if (bad < 30) $display("FAIL iss0_data cyc=%0d got c=%0d ch=%0d a=%0d want c=%0d ch=%0d a=%0d",
                  cyc, bus0.coeff_sel, bus0.ch_sel, bus0.acc_init, e.coeff, e.ch, e.acc);
              end
            end
          end
          if (bus0.wr_en) begin
            total++;
            if (q_wr0.size() == 0 || q_wr0[0].cyc != cyc) begin
              bad++; if (bad < 30) $display("FAIL wr0_unexpected cyc=%0d ch=%0d", cyc, bus0.wr_ch);
            end else begin
              r = q_wr0.pop_front();
              if (int'(bus0.wr_ch) !== r.ch) begin
                bad++; if (bad < 30) $display("FAIL wr0_ch cyc=%0d got %0d want %0d", cyc, bus0.wr_ch, r.ch);
              end
            end
          end
        end
      end
      forever begin : mon1
        iss_t e;
        wr_t  r;
        @(negedge clk);
        if (GlobalReset) begin
          while (q_iss1.size() > 0 && q_iss1[0].cyc < cyc) begin
            total++; bad++;
            if (bad < 30) $display("FAIL iss1_missing want_cyc=%0d now=%0d", q_iss1[0].cyc, cyc);
            q_iss1.delete(0);
          end
          while (q_wr1.size() > 0 && q_wr1[0].cyc < cyc) begin
            total++; bad++;
            if (bad < 30) $display("FAIL wr1_missing want_cyc=%0d now=%0d", q_wr1[0].cyc, cyc);
            q_wr1.delete(0);
          end
          if (bus1.iss_valid) begin
            total++;
            if (q_iss1.size() == 0 || q_iss1[0].cyc != cyc) begin
              bad++; if (bad < 30) $display("FAIL iss1_unexpected cyc=%0d ch=%0d", cyc, bus1.ch_sel);
            end else begin
              e = q_iss1.pop_front();
              if (int'(bus1.coeff_sel) !== e.coeff || int'(bus1.ch_sel) !== e.ch ||
                  int'(bus1.acc_init) !== e.acc) begin
                bad++; if (bad < 30) $display("FAIL iss1_data cyc=%0d got c=%0d ch=%0d a=%0d want c=%0d ch=%0d a=%0d",
                  cyc, bus1.coeff_sel, bus1.ch_sel, bus1.acc_init, e.coeff, e.ch, e.acc);
              end
            end
          end
          if (bus1.wr_en) begin
            total++;
            if (q_wr1.size() == 0 || q_wr1[0].cyc != cyc) begin
              bad++; if (bad < 30) $display("FAIL wr1_unexpected cyc=%0d ch=%0d", cyc, bus1.wr_ch);
            end else begin
              r = q_wr1.pop_front();
              if (int'(bus1.wr_ch) !== r.ch) begin
                bad++; if (bad < 30) $display("FAIL wr1_ch cyc=%0d got %0d want %0d", cyc, bus1.wr_ch, r.ch);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_single();
    repeat (3) next();
    test_backpressure();
    repeat (3) next();
    test_pending();
    repeat (3) next();
    test_overrun();
    repeat (3) next();
    test_midreset();
    repeat (3) next();
    test_sweep();
    repeat (3) next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
